// File: rtl/sp_pc_unit_if.sv
// Decoder/fetch-side bundle for sp_pc_unit: op request in, architectural PC/SP state out.
interface sp_pc_unit_if #(
  parameter int unsigned WIDTH = 16
);
  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic             resume;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] sp;
  logic             halted;
  logic             fault;
  logic [WIDTH-1:0] fault_pc;

  modport master (
    output en, op, operand, resume,
    input  pc, sp, halted, fault, fault_pc
  );

  modport slave (
    input  en, op, operand, resume,
    output pc, sp, halted, fault, fault_pc
  );
endinterface

// File: rtl/sp_pc_unit.sv
// Registered SP/PC update unit: one control-flow or stack op per enabled cycle, with HALT/FAULT.
// Define SP_BOUNDS_CHECK_EN to trap SP updates that leave [SP_LO, SP_HI].
module sp_pc_unit #(
  parameter int unsigned      WIDTH        = 16,
  parameter logic [WIDTH-1:0] PC_RESET     = '0,
  parameter logic [WIDTH-1:0] SP_RESET     = WIDTH'(16'hFFFF),
  parameter logic [WIDTH-1:0] PC_STEP      = WIDTH'(1),
  parameter logic [WIDTH-1:0] SP_STEP      = WIDTH'(1),
  parameter logic [WIDTH-1:0] SP_LO        = WIDTH'(16'h8000),
  parameter logic [WIDTH-1:0] SP_HI        = WIDTH'(16'hFFFF),
  parameter logic [WIDTH-1:0] FAULT_VECTOR = WIDTH'(16'h0010)
) (
  input  logic        clk,
  input  logic        rst_n,
  sp_pc_unit_if.slave bus
);

`ifdef SP_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_CHGSP = 3'b001,
    OP_SETSP = 3'b010,
    OP_CHGPC = 3'b011,
    OP_SETPC = 3'b100,
    OP_PUSH  = 3'b101,
    OP_POP   = 3'b110,
    OP_HALT  = 3'b111
  } op_e;

  state_e           state;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] sp_q;
  logic             halted_q;
  logic             fault_q;
  logic [WIDTH-1:0] fault_pc_q;

  op_e              opc;
  logic [WIDTH-1:0] pc_step;
  logic [WIDTH-1:0] sp_cand;
  logic             sp_oob;

  // Candidate SP is formed for every op; it only matters for the four stack ops.
  always_comb begin
    opc     = op_e'(bus.op);
    pc_step = pc_q + PC_STEP;
    sp_cand = sp_q;
    unique case (opc)
      OP_CHGSP: sp_cand = sp_q + bus.operand;
      OP_SETSP: sp_cand = bus.operand;
      OP_PUSH:  sp_cand = sp_q - SP_STEP;
      OP_POP:   sp_cand = sp_q + SP_STEP;
      default:  sp_cand = sp_q;
    endcase
    sp_oob = BOUNDS_EN && ((sp_cand < SP_LO) || (sp_cand > SP_HI));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      pc_q       <= PC_RESET;
      sp_q       <= SP_RESET;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.en) begin
            unique case (opc)
              OP_NOP:   pc_q <= pc_step;
              OP_CHGPC: pc_q <= pc_q + bus.operand;
              OP_SETPC: pc_q <= bus.operand;
              OP_HALT: begin
                state    <= ST_HALT;
                halted_q <= 1'b1;
              end
              default: begin
                // Stack ops: an out-of-range SP traps without touching pc or sp.
                if (sp_oob) begin
                  state      <= ST_FAULT;
                  fault_q    <= 1'b1;
                  fault_pc_q <= pc_q;
                end else begin
                  sp_q <= sp_cand;
                  pc_q <= pc_step;
                end
              end
            endcase
          end
        end
        ST_HALT: begin
          if (bus.resume) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
            pc_q     <= pc_step;
          end
        end
        ST_FAULT: begin
          if (bus.resume) begin
            state   <= ST_RUN;
            fault_q <= 1'b0;
            pc_q    <= FAULT_VECTOR;
          end
        end
        default: begin
          state    <= ST_RUN;
          halted_q <= 1'b0;
          fault_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pc       = pc_q;
  assign bus.sp       = sp_q;
  assign bus.halted   = halted_q;
  assign bus.fault    = fault_q;
  assign bus.fault_pc = fault_pc_q;

endmodule
